// File: rtl/otter_mem_arbiter.sv
// Fetch/data arbiter for a shared single-port memory: one outstanding transaction,
// data-over-fetch priority with a fairness streak that eventually forces a fetch grant.
module otter_mem_arbiter #(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned FAIR_MAX = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [1:0]  d_size_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        m_en_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [1:0]  m_size_o,
  input  logic [31:0] m_rdata_i,
  output logic        stall_if_o,
  output logic        stall_mem_o
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] streak_q, streak_d;
  logic       we_q, we_d;

  logic busy, resp, slot, fair_force, gnt_i, gnt_d;

  assign busy       = (state_q != StIdle);
  assign resp       = busy && (cnt_q == 3'd1);
  // A grant slot is IDLE or the response cycle, and never while reset is asserted.
  assign slot       = rst_ni && (!busy || resp);
  assign fair_force = if_req_i && (streak_q >= 2'(FAIR_MAX));
  assign gnt_d      = slot && d_req_i && !fair_force;
  assign gnt_i      = slot && if_req_i && !gnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    we_d     = we_q;
    if (busy) begin
      cnt_d = cnt_q - 3'd1;
      if (resp) begin
        state_d = StIdle;
      end
    end
    if (gnt_d) begin
      state_d  = StBusyD;
      cnt_d    = 3'(MEM_LAT);
      we_d     = d_we_i;
      streak_d = if_req_i ? streak_q + 2'd1 : 2'd0;
    end else if (gnt_i) begin
      state_d  = StBusyI;
      cnt_d    = 3'(MEM_LAT);
      we_d     = 1'b0;
      streak_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      streak_q <= 2'd0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      we_q     <= we_d;
    end
  end

  always_comb begin
    if_gnt_o    = gnt_i;
    d_gnt_o     = gnt_d;
    if_rvalid_o = rst_ni && resp && (state_q == StBusyI);
    d_rvalid_o  = rst_ni && resp && (state_q == StBusyD);
    if_rdata_o  = if_rvalid_o ? m_rdata_i : 32'h0;
    // Stores complete with zero data.
    d_rdata_o   = (d_rvalid_o && !we_q) ? m_rdata_i : 32'h0;
    m_en_o      = gnt_i || gnt_d;
    m_we_o      = gnt_d && d_we_i;
    m_addr_o    = gnt_d ? d_addr_i : (gnt_i ? if_addr_i : 32'h0);
    m_wdata_o   = gnt_d ? d_wdata_i : 32'h0;
    m_size_o    = gnt_d ? d_size_i : (gnt_i ? 2'b10 : 2'b00);
    stall_if_o  = rst_ni && if_req_i && !if_rvalid_o;
    stall_mem_o = rst_ni && d_req_i && !d_rvalid_o;
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: four instances with different latency/fairness settings
// share stimulus and are checked every cycle against a timestamp-based transaction model.
module tb_otter_mem_arbiter;

  localparam int N = 4;

  function automatic int lat_of(input int k);
    return k + 1;
  endfunction

  function automatic int fair_of(input int k);
    case (k)
      1:       return 3;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;

  logic        if_gnt[N], if_rvalid[N], d_gnt[N], d_rvalid[N];
  logic        m_en[N], m_we[N], stall_if[N], stall_mem[N];
  logic [31:0] if_rdata[N], d_rdata[N], m_addr[N], m_wdata[N];
  logic [1:0]  m_size[N];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    otter_mem_arbiter #(
      .MEM_LAT (lat_of(g)),
      .FAIR_MAX(fair_of(g))
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_gnt_o   (if_gnt[g]),
      .if_rvalid_o(if_rvalid[g]),
      .if_rdata_o (if_rdata[g]),
      .d_req_i    (d_req),
      .d_we_i     (d_we),
      .d_addr_i   (d_addr),
      .d_wdata_i  (d_wdata),
      .d_size_i   (d_size),
      .d_gnt_o    (d_gnt[g]),
      .d_rvalid_o (d_rvalid[g]),
      .d_rdata_o  (d_rdata[g]),
      .m_en_o     (m_en[g]),
      .m_we_o     (m_we[g]),
      .m_addr_o   (m_addr[g]),
      .m_wdata_o  (m_wdata[g]),
      .m_size_o   (m_size[g]),
      .m_rdata_i  (m_rdata),
      .stall_if_o (stall_if[g]),
      .stall_mem_o(stall_mem[g])
    );
  end

  function automatic void chk(input string name, input logic [137:0] act,
                              input logic [137:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endfunction

  function automatic logic [137:0] act_vec(input int k);
    return {if_gnt[k], if_rvalid[k], if_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k],
            m_en[k], m_we[k], m_addr[k], m_wdata[k], m_size[k], stall_if[k], stall_mem[k]};
  endfunction

  // Model: each instance tracks the outstanding transaction by the cycle number its
  // response is due, plus the count of consecutive data wins taken while a fetch waited.
  bit mb_busy[N];
  bit mb_data[N];
  bit mb_store[N];
  int mb_due[N];
  int mb_streak[N];
  int cyc = 0;

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic [137:0] expv;
      logic resp, free, dg, ig, irv, drv;
      if (!rst_n) begin
        expv         = '0;
        mb_busy[k]   = 1'b0;
        mb_streak[k] = 0;
      end else begin
        resp = mb_busy[k] && (cyc == mb_due[k]);
        free = !mb_busy[k] || resp;
        dg   = free && d_req && !(if_req && (mb_streak[k] >= fair_of(k)));
        ig   = free && if_req && !dg;
        irv  = resp && !mb_data[k];
        drv  = resp && mb_data[k];
        expv = {ig, irv, irv ? m_rdata : 32'h0,
                dg, drv, (drv && !mb_store[k]) ? m_rdata : 32'h0,
                dg | ig, dg & d_we,
                dg ? d_addr : (ig ? if_addr : 32'h0),
                dg ? d_wdata : 32'h0,
                dg ? d_size : (ig ? 2'b10 : 2'b00),
                if_req & !irv, d_req & !drv};
        if (dg || ig) begin
          mb_busy[k]   = 1'b1;
          mb_data[k]   = dg;
          mb_store[k]  = dg & d_we;
          mb_due[k]    = cyc + lat_of(k);
          mb_streak[k] = (dg && if_req) ? mb_streak[k] + 1 : 0;
        end else if (resp) begin
          mb_busy[k] = 1'b0;
        end
      end
      chk($sformatf("model inst%0d cyc%0d", k, cyc), act_vec(k), expv);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_size  = 2'b00;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    quiet_inputs();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    string seq;
    byte   got;
    rst_n   = 1'b0;
    quiet_inputs();
    if_req  = 1'b1;
    d_req   = 1'b1;
    m_rdata = 32'h5555_AAAA;

    // Reset held with both requests high: everything quiet.
    repeat (3) tick();
    smp();
    chk("reset quiet inst0", act_vec(0), '0);
    chk("reset quiet inst3", act_vec(3), '0);
    chk("reset stall_if", stall_if[1], 1'b0);

    // Single fetch, latency 1.
    tick();
    rst_n   = 1'b1;
    d_req   = 1'b0;
    if_addr = 32'h0000_0100;
    m_rdata = 32'h0000_0013;
    smp();
    chk("fetch if_gnt t", if_gnt[0], 1'b1);
    chk("fetch m_addr t", m_addr[0], 32'h0000_0100);
    chk("fetch m_size t", m_size[0], 2'b10);
    tick();
    smp();
    chk("fetch if_rvalid t+1", if_rvalid[0], 1'b1);
    chk("fetch if_rdata t+1", if_rdata[0], 32'h0000_0013);
    chk("fetch stall_if t+1", stall_if[0], 1'b0);
    tick();
    do_reset(2);

    // Store, latency 3.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h1100_0000;
    d_wdata = 32'hDEAD_BEEF;
    d_size  = 2'b10;
    smp();
    chk("store m_en t", m_en[2], 1'b1);
    chk("store m_we t", m_we[2], 1'b1);
    chk("store m_addr t", m_addr[2], 32'h1100_0000);
    chk("store m_wdata t", m_wdata[2], 32'hDEAD_BEEF);
    chk("store m_size t", m_size[2], 2'b10);
    chk("store stall t", stall_mem[2], 1'b1);
    tick();
    smp();
    chk("store m_en t+1", m_en[2], 1'b0);
    chk("store m_addr t+1", m_addr[2], 32'h0);
    chk("store stall t+1", stall_mem[2], 1'b1);
    tick();
    smp();
    chk("store d_rvalid t+2", d_rvalid[2], 1'b0);
    chk("store stall t+2", stall_mem[2], 1'b1);
    tick();
    d_req = 1'b0;
    smp();
    chk("store d_rvalid t+3", d_rvalid[2], 1'b1);
    chk("store d_rdata t+3", d_rdata[2], 32'h0);
    tick();
    do_reset(2);

    // Both requesters held, latency 1, fairness 2.
    if_req = 1'b1;
    d_req  = 1'b1;
    seq    = "DDIDDI";
    for (int i = 0; i < 6; i++) begin
      smp();
      if (d_gnt[0] && if_gnt[0]) got = "X";
      else if (d_gnt[0])         got = "D";
      else if (if_gnt[0])        got = "I";
      else                       got = "-";
      chk($sformatf("fair order %0d", i), got, seq[i]);
      tick();
    end
    do_reset(2);

    // Back-to-back loads, latency 2.
    d_addr = 32'h0000_2000;
    for (int i = 0; i < 7; i++) begin
      d_req   = (i < 5);
      m_rdata = 32'hA000_0000 + i;
      smp();
      chk($sformatf("b2b d_gnt %0d", i), d_gnt[1], (i == 0 || i == 2 || i == 4));
      chk($sformatf("b2b d_rvalid %0d", i), d_rvalid[1], (i == 2 || i == 4 || i == 6));
      chk($sformatf("b2b d_rdata %0d", i), d_rdata[1],
          (i == 2 || i == 4 || i == 6) ? 32'hA000_0000 + i : 32'h0);
      tick();
    end
    do_reset(2);

    // Reset mid-transaction, latency 4.
    d_req = 1'b1;
    smp();
    chk("abort d_gnt t", d_gnt[3], 1'b1);
    tick();
    d_req = 1'b0;
    smp();
    tick();
    rst_n = 1'b0;
    smp();
    chk("abort quiet t+2", act_vec(3), '0);
    tick();
    rst_n = 1'b1;
    d_req = 1'b1;
    smp();
    chk("abort regrant t+3", d_gnt[3], 1'b1);
    tick();
    d_req = 1'b0;
    smp();
    chk("abort no rvalid t+4", d_rvalid[3], 1'b0);
    tick();
    do_reset(2);

    // Random traffic with occasional reset.
    repeat (4000) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      if_req  = ($urandom_range(0, 2) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1);
      if_addr = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_size  = 2'($urandom_range(0, 3));
      m_rdata = $urandom;
      tick();
    end
    smp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
OTTER_MEM_ARBITER -- requirements
Module: otter_mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, meaning cycles from grant to response (legal 1..7).
REQ-002 The block SHALL have parameter FAIR_MAX, default 2, meaning consecutive data grants allowed while a fetch waits (legal 1..3).
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 CLOCK  input  1  sole clock; all state changes on rising edge.
REQ-005 RESET_N  input  1  synchronous active-low reset.
REQ-006 IF_REQ  input  1  fetch request; IF_ADDR  input  32  fetch address.
REQ-007 IF_GNT  output  1  fetch accepted this cycle; IF_RVALID  output  1  fetch response; IF_RDATA  output  32  instruction word.
REQ-008 D_REQ  input  1; D_WE  input  1; D_ADDR  input  32; D_WDATA  input  32; D_SIZE  input  2: data-stage request fields.
REQ-009 D_GNT  output  1; D_RVALID  output  1  load data or store completion; D_RDATA  output  32.
REQ-010 M_EN, M_WE  output  1; M_ADDR, M_WDATA  output  32; M_SIZE  output  2; M_RDATA  input  32: shared single-port memory.
REQ-011 STALL_IF, STALL_MEM  output  1  pipeline stall to fetch and memory stages.

Function
REQ-012 The block SHALL keep at most one transaction outstanding, using states IDLE, BUSY_I, BUSY_D.
REQ-013 In IDLE or a response cycle, a grant SHALL issue combinationally in the same cycle the winning REQ is high: GNT=1, M_EN=1, M_* driven from winner (fetch: M_WE=0, M_SIZE=2'b10, M_WDATA=0).
REQ-014 A grant SHALL load a 3-bit counter with MEM_LAT and enter BUSY_I or BUSY_D; each BUSY cycle decrements it.
REQ-015 The response (RVALID=1 for exactly one cycle) SHALL occur exactly MEM_LAT cycles after the grant cycle; RDATA = M_RDATA in that cycle, else 0.
REQ-016 Stores SHALL also return D_RVALID after MEM_LAT cycles, with D_RDATA=0.
REQ-017 In the response cycle a pending request SHALL be granted (back-to-back), giving one transaction per MEM_LAT cycles; the state returns to IDLE only if nothing is pending.
REQ-018 Priority SHALL be data over fetch, except after FAIR_MAX consecutive data grants while IF_REQ was high, the next grant SHALL go to fetch; the streak counter clears on any fetch grant or any data grant with IF_REQ low.
REQ-019 M_EN, M_WE, GNT SHALL be 0 in all non-grant cycles; M_ADDR/M_WDATA/M_SIZE SHALL be 0 when M_EN=0.
REQ-020 Requesters hold REQ and fields stable until GNT; REQ still high in the cycle after RVALID SHALL be treated as a new request.
REQ-021 STALL_IF = IF_REQ & ~IF_RVALID; STALL_MEM = D_REQ & ~D_RVALID; both SHALL be 0 while RESET_N=0.
REQ-022 Simultaneous IF_REQ and D_REQ in a grant slot SHALL grant exactly one requester per REQ-018; the loser keeps STALL high.

Reset
REQ-023 RESET_N=0 at a rising edge SHALL force IDLE, counter=0, streak=0; all outputs SHALL be 0 while RESET_N=0.
REQ-024 Reset during BUSY SHALL abandon the transaction: no RVALID after release; first post-reset request is granted in the first cycle RESET_N=1.

Verification
REQ-025 MEM_LAT=1, IF_REQ=1, IF_ADDR=0x0000_0100, M_RDATA=0x0000_0013 -> IF_GNT cycle t, IF_RVALID=1 and IF_RDATA=0x0000_0013 at t+1, STALL_IF=0 at t+1.
REQ-026 MEM_LAT=3, D_REQ=1, D_WE=1, D_ADDR=0x1100_0000, D_WDATA=0xDEAD_BEEF, D_SIZE=2'b10 -> M_EN=M_WE=1 with those values at t only, D_RVALID at t+3, STALL_MEM=1 for t..t+2.
REQ-027 MEM_LAT=1, IF_REQ and D_REQ both held high -> grant order D, D, I, D, D, I; no cycle with both GNTs.
REQ-028 MEM_LAT=2, back-to-back data loads -> grants at t, t+2, t+4; responses at t+2, t+4, t+6 with M_RDATA passed through.
REQ-029 MEM_LAT=4, RESET_N=0 at t+2 after grant at t for one cycle -> no D_RVALID at t+4; new D_REQ granted at t+3.
REQ-030 Hold RESET_N=0 with IF_REQ=D_REQ=1 -> all outputs 0 including STALL_IF, STALL_MEM.
